uart_boot_loader: RTL and testbench

// - Upstream loader for the core's instruction memory. Receives a program over UART, writes it

---
 rtl/uart_boot_loader.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a program over an 8N1 UART, writes it word by word into instruction
// memory starting at MEM_BASE, then releases the core from reset.
//
// Byte protocol: 0xA5 sync, LEN_LO, LEN_HI (word count, little endian), LEN*4 payload bytes
// (each word little endian). Optional trailing checksum byte, see below.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous active-high reset
//   uart_rx   asynchronous serial input, idle high, LSB first
//   im_wen    instruction-memory write strobe, one-cycle pulse per word
//   im_addr   word-aligned write byte address
//   im_wdata  write data
//   core_rst  core reset, held high until the load completes
//   busy      load in progress (sync accepted, not yet DONE/ERROR)
//   done      load completed, terminal
//   error     load failed (bad length, framing error, bad checksum), terminal until rst
//
// Build option: define BOOT_CHECKSUM_EN to add a CHECK state after the last word. The next byte
// must equal the XOR of all payload bytes; a match goes to DONE, anything else to ERROR.

module uart_boot_loader #(
  parameter int unsigned CLK_FREQ_HZ = 27_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
  parameter int unsigned MAX_WORDS   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        im_wen,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned ClksPerBit = CLK_FREQ_HZ / BAUD;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] FullLast = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
  localparam logic [7:0] SyncByte = 8'hA5;

  // ---------------------------------------------------------------------------------------------
  // RX front end
  // ---------------------------------------------------------------------------------------------

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_valid;
  logic            rx_ferr;
  logic [7:0]      rx_byte;

  assign rx_byte = shift_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_valid   = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        cnt_d = '0;
        // Only a high-to-low transition starts a frame, so a line stuck low stays silent.
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d      = '0;
          bit_d      = '0;
          rx_state_d = rx_s2_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            rx_state_d = RxStop;
          end
        end
      end
      RxStop: begin
        if (cnt_q == FullLast) begin
          cnt_d      = '0;
          rx_state_d = RxIdle;
          if (rx_s2_q) begin
            rx_valid = 1'b1;
          end else begin
            rx_ferr = 1'b1;
          end
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Load protocol FSM
  // ---------------------------------------------------------------------------------------------

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StCheck, StDone, StError
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StDone, StError
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [15:0] len_full;
  logic        len_bad;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign len_full = {rx_byte, len_q[7:0]};
  assign len_bad  = (len_full == 16'd0) || (32'(len_full) > MAX_WORDS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      wdata_q    <= '0;
      addr_q     <= MEM_BASE;
      wen_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    wen_d      = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (rx_ferr) begin
          state_d = StError;
        end else if (rx_valid && (rx_byte == SyncByte)) begin
          state_d    = StLenLo;
          word_idx_d = '0;
          byte_idx_d = '0;
`ifdef BOOT_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      StLenLo: begin
        if (rx_ferr) begin
          state_d = StError;
        end else if (rx_valid) begin
          len_d   = {8'h00, rx_byte};
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (rx_ferr) begin
          state_d = StError;
        end else if (rx_valid) begin
          len_d   = len_full;
          state_d = len_bad ? StError : StData;
        end
      end
      StData: begin
        // word_idx reaches len on the cycle im_wen is high for the last word; leaving DATA one
        // cycle later places done/core_rst release on the cycle after that write pulse.
        if (word_idx_q == len_q) begin
`ifdef BOOT_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else if (rx_ferr) begin
          state_d = StError;
        end else if (rx_valid) begin
          wdata_d[8*byte_idx_q +: 8] = rx_byte;
          byte_idx_d                 = byte_idx_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          csum_d                     = csum_q ^ rx_byte;
`endif
          if (byte_idx_q == 2'd3) begin
            wen_d      = 1'b1;
            addr_d     = MEM_BASE + {14'd0, word_idx_q, 2'b00};
            word_idx_d = word_idx_q + 16'd1;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      StCheck: begin
        if (rx_ferr) begin
          state_d = StError;
        end else if (rx_valid) begin
          state_d = (rx_byte == csum_q) ? StDone : StError;
        end
      end
`endif
      StDone:  state_d = StDone;
      StError: state_d = StError;
      default: state_d = StError;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------

  assign im_wen   = wen_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign core_rst = (state_q != StDone);
  assign done     = (state_q == StDone);
  assign error    = (state_q == StError);
`ifdef BOOT_CHECKSUM_EN
  assign busy     = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData) ||
                    (state_q == StCheck);
`else
  assign busy     = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader: drives UART frames at 16 clocks/bit, predicts memory writes and
// the final load status from a byte-level protocol model, and checks writes through a scoreboard
// drained by an independent monitor. Honours BOOT_CHECKSUM_EN for the optional checksum byte.

module tb_uart_boot_loader;

  localparam int unsigned ClkFreq  = 16;
  localparam int unsigned Baud     = 1;
  localparam int unsigned MaxWords = 4;
  localparam int unsigned Cpb      = ClkFreq / Baud;
  localparam logic [31:0] MemBase  = 32'h8000_0000;
  // A frame starting at negedge N0 has its stop-bit rx_valid after posedge 154 (2 synchroniser
  // flops, edge detect, half bit, 8 data bits, stop midpoint); im_wen follows one cycle later.
  localparam int unsigned WenLat   = 155;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        im_wen;
  logic [31:0] im_addr, im_wdata;
  logic        core_rst, busy, done, error;

  uart_boot_loader #(
    .CLK_FREQ_HZ(ClkFreq),
    .BAUD       (Baud),
    .MEM_BASE   (MemBase),
    .MAX_WORDS  (MaxWords)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .im_wen  (im_wen),
    .im_addr (im_addr),
    .im_wdata(im_wdata),
    .core_rst(core_rst),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard and monitor
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned due;
    bit          last;
  } wr_t;

  wr_t         sb[$];
  bit          done_pend = 0;
  int unsigned done_due  = 0;

  always @(negedge clk) begin
    wr_t e;
    if (done_pend && cyc == done_due) begin
      done_pend = 0;
      check("done_core_rst_after_last_wen", {30'd0, done, core_rst}, 32'd2);
    end
    if (im_wen === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wen: got write %h<=%h at cycle %0d, expected none",
                 im_addr, im_wdata, cyc);
      end else begin
        e = sb.pop_front();
        check("wen_addr", im_addr, e.addr);
        check("wen_data", im_wdata, e.data);
        check("wen_cycle", cyc, e.due);
        check("done_low_during_wen", {31'd0, done}, 32'd0);
        if (e.last) begin
          done_pend = 1;
          done_due  = cyc + 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- reference model
  logic [7:0]  stim[$];
  bit          wr_at[];
  bit          wr_last[];
  logic [31:0] wr_addr[];
  logic [31:0] wr_data[];
  int          exp_status;  // 0 idle, 1 busy, 2 done, 3 error

  task automatic build_model();
    int n = stim.size();
    int i = 0;
    int len;
    logic [7:0] x = 8'h00;
    wr_at   = new[n];
    wr_last = new[n];
    wr_addr = new[n];
    wr_data = new[n];
    for (int k = 0; k < n; k++) begin
      wr_at[k]   = 0;
      wr_last[k] = 0;
      wr_addr[k] = '0;
      wr_data[k] = '0;
    end
    exp_status = 0;
    while (i < n && stim[i] != 8'hA5) i++;
    if (i >= n) return;
    i++;
    exp_status = 1;
    if (i + 1 >= n) return;
    len = int'(stim[i]) + 256 * int'(stim[i+1]);
    i += 2;
    if (len == 0 || len > int'(MaxWords)) begin
      exp_status = 3;
      return;
    end
    for (int w = 0; w < len; w++) begin
      if (i + 3 >= n) return;
      wr_at[i+3]   = 1;
      wr_addr[i+3] = MemBase + 32'(4 * w);
      wr_data[i+3] = {stim[i+3], stim[i+2], stim[i+1], stim[i]};
      x = x ^ stim[i] ^ stim[i+1] ^ stim[i+2] ^ stim[i+3];
      i += 4;
    end
`ifdef BOOT_CHECKSUM_EN
    if (i < n) exp_status = (stim[i] == x) ? 2 : 3;
`else
    wr_last[i-1] = 1;
    exp_status   = 2;
`endif
  endtask

  // Appends the correct checksum byte for payload stim[start..end] when the option is built in.
  task automatic add_csum(input int start);
`ifdef BOOT_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int k = start; k < stim.size(); k++) x ^= stim[k];
    stim.push_back(x);
`else
    if (start < 0) $display("add_csum: negative start");
`endif
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    uart_rx = stop;
    repeat (Cpb) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic check_status(input string name, input int s);
    logic [3:0] want;
    want = {s == 1, s == 2, s == 3, s != 2};
    check(name, {28'd0, busy, done, error, core_rst}, {28'd0, want});
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check({name, "_wen"}, {31'd0, im_wen}, 32'd0);
    check({name, "_addr"}, im_addr, MemBase);
    check({name, "_wdata"}, im_wdata, 32'd0);
    check_status({name, "_status"}, 0);
    rst = 1'b0;
    sb.delete();
    done_pend = 0;
    @(negedge clk);
  endtask

  task automatic run_load(input string name);
    build_model();
    for (int k = 0; k < stim.size(); k++) begin
      if (wr_at[k]) sb.push_back('{wr_addr[k], wr_data[k], cyc + WenLat, wr_last[k]});
      send_frame(stim[k], 1'b1);
    end
    repeat (20) @(negedge clk);
    check_status({name, "_status"}, exp_status);
    check({name, "_pending_writes"}, sb.size(), 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [7:0] b;
    int         len, r, p0;

    do_reset("reset0");

    // Leading noise byte, then a one-word load.
    stim = '{8'h00, 8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    add_csum(4);
    run_load("one_word");

    // Two words.
    do_reset("reset1");
    stim = '{8'hA5, 8'h02, 8'h00};
    for (int k = 0; k < 8; k++) stim.push_back(8'h11 + 8'(k));
    add_csum(3);
    run_load("two_words");

    // Length out of range and zero length.
    do_reset("reset2");
    stim = '{8'hA5, 8'h05, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    run_load("len_too_big");
    do_reset("reset3");
    stim = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    run_load("len_zero");

    // Framing error in DATA, then more traffic that must not write.
    do_reset("reset4");
    stim = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    run_load("pre_ferr");
    send_frame(8'h33, 1'b0);
    repeat (Cpb) @(negedge clk);
    check_status("ferr_status", 3);
    for (int k = 0; k < 6; k++) send_frame(8'h40 + 8'(k), 1'b1);
    repeat (20) @(negedge clk);
    check_status("ferr_after_traffic", 3);
    do_reset("reset5");

    // Reset after one of two words, then a fresh complete load.
    stim = '{8'hA5, 8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
    run_load("partial");
    do_reset("mid_rst");
    stim = '{8'hA5, 8'h02, 8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    add_csum(3);
    run_load("reload");

    // Line held low (break) during the header.
    do_reset("reset6");
    stim = '{8'hA5, 8'h01, 8'h00};
    run_load("pre_break");
    uart_rx = 1'b0;
    repeat (400) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    check_status("break_status", 3);

`ifdef BOOT_CHECKSUM_EN
    do_reset("reset_ck0");
    stim = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
    run_load("csum_good");
    do_reset("reset_ck1");
    stim = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
    run_load("csum_bad");
`endif

    // Randomized loads: noise, good and bad lengths, random payloads, trailing junk.
    for (int it = 0; it < 8; it++) begin
      do_reset("reset_rand");
      stim.delete();
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        stim.push_back(b);
      end
      stim.push_back(8'hA5);
      r = int'($urandom_range(0, 9));
      if (r == 0) len = 0;
      else if (r == 1) len = int'($urandom_range(5, 9));
      else if (r == 2) len = 256 * int'($urandom_range(1, 3)) + int'($urandom_range(0, 3));
      else len = int'($urandom_range(1, MaxWords));
      stim.push_back(8'(len));
      stim.push_back(8'(len >> 8));
      p0 = stim.size();
      if (len >= 1 && len <= int'(MaxWords)) begin
        for (int k = 0; k < 4 * len; k++) stim.push_back(8'($urandom));
        add_csum(p0);
`ifdef BOOT_CHECKSUM_EN
        if ($urandom_range(0, 2) == 0) stim[stim.size()-1] = stim[stim.size()-1] ^ 8'h01;
`endif
      end else begin
        for (int k = 0; k < 4; k++) stim.push_back(8'($urandom));
      end
      stim.push_back(8'($urandom));
      run_load("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
